// File: rtl/riscv_mem_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package riscv_mem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } arb_gnt_e;
endpackage

// File: rtl/arb_timeout_timer.sv
// Busy-cycle counter: cleared on a grant, counts each busy cycle, flags the
// last allowed busy cycle so the arbiter can abort a hung access.
module arb_timeout_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic busy,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= '0;
    else if (busy && !expired) cnt <= cnt + 1'b1;
  end

  // First busy cycle sees cnt==0, so TIMEOUT-1 marks the TIMEOUT-th busy cycle.
  assign expired = busy && (cnt == TW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (read-only) and data (read/write)
// with data priority, a fetch starvation guard, and a ready timeout.
module mem_port_arbiter #(
  parameter int ADDR_W     = riscv_mem_pkg::ADDR_W,
  parameter int DATA_W     = riscv_mem_pkg::DATA_W,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
);
  import riscv_mem_pkg::*;

  localparam int SW = $clog2(MAX_STREAK + 1);

  arb_state_e    state, state_nxt;
  arb_gnt_e      gnt;
  logic          gnt_vld;
  logic          busy, expired, done;
  logic [SW-1:0] streak;

  assign busy = (state != ARB_IDLE);
  assign done = busy && (mem_ready_i || expired);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_vld   = 1'b0;
    gnt       = GNT_DM;
    case (state)
      ARB_IDLE: begin
        // Data wins unless fetch has already waited out MAX_STREAK data grants.
        if (dm_req_i && !(if_req_i && streak == SW'(MAX_STREAK))) begin
          gnt_vld   = 1'b1;
          gnt       = GNT_DM;
          state_nxt = ARB_BUSY_DM;
        end else if (if_req_i) begin
          gnt_vld   = 1'b1;
          gnt       = GNT_IF;
          state_nxt = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_DM: if (done) state_nxt = ARB_IDLE;
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (state == ARB_IDLE) begin
      if (!if_req_i || (gnt_vld && gnt == GNT_IF)) streak <= '0;
      else if (gnt_vld && streak != SW'(MAX_STREAK)) streak <= streak + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (gnt_vld) begin
      mem_req_o <= 1'b1;
      if (gnt == GNT_DM) begin
        mem_we_o    <= dm_we_i;
        mem_addr_o  <= dm_addr_i;
        mem_wdata_o <= dm_wdata_i;
      end else begin
        mem_we_o    <= 1'b0;
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= '0;
      end
    end else if (done) begin
      mem_req_o <= 1'b0;
    end
  end

  arb_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (gnt_vld),
    .busy    (busy),
    .expired (expired)
  );

  // A ready arriving on the timeout cycle completes normally.
  assign if_valid_o  = (state == ARB_BUSY_IF) && (mem_ready_i || expired);
  assign dm_valid_o  = (state == ARB_BUSY_DM) && (mem_ready_i || expired);
  assign if_rdata_o  = (state == ARB_BUSY_IF && mem_ready_i) ? mem_rdata_i : '0;
  assign dm_rdata_o  = (state == ARB_BUSY_DM && mem_ready_i) ? mem_rdata_i : '0;
  assign err_o       = busy && expired && !mem_ready_i;

  assign stall_if_o  = if_req_i && !if_valid_o;
  assign stall_mem_o = dm_req_i && !dm_valid_o;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port instruction/data memory between the fetch stage (read-only) and the memory stage (read/write) of the 5-stage RISC-V pipeline. It runs a grant state machine with data-side priority and a starvation guard for fetch. It also has a memory-ready timeout, and produces the per-stage stall signals the pipeline control uses to freeze PC, IF/ID and EX/MEM while an access is outstanding. It sits between the pipeline's fetch/data ports and the shared memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_STREAK, 4, consecutive data grants allowed while fetch waits
- TIMEOUT, 16, cycles in a busy state without mem_ready_i before abort (≥2)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request level; held until if_valid_o
- if_addr_i  in  ADDR_W  fetch address, stable while if_req_i
- if_rdata_o  out  DATA_W  fetch read data, valid with if_valid_o
- if_valid_o  out  1  fetch completion, one cycle
- dm_req_i  in  1  data request level; held until dm_valid_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_rdata_o  out  DATA_W  load data, valid with dm_valid_o
- dm_valid_o  out  1  data completion, one cycle
- err_o  out  1  one-cycle pulse alongside a valid that ended by timeout
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  memory write enable, registered
- mem_addr_o  out  ADDR_W  registered address
- mem_wdata_o  out  DATA_W  registered write data
- mem_rdata_i  in  DATA_W  memory read data, valid when mem_ready_i
- mem_ready_i  in  1  memory completes the access this cycle
- stall_if_o  out  1  freeze PC and IF/ID
- stall_mem_o  out  1  freeze the pipeline at EX/MEM and upstream

## Operation
- States: ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_DM.
- **ARB_IDLE**
  - With no request: stay.
  - dm_req_i only: grant data. if_req_i only: grant fetch.
  - Both requesting: grant data unless streak == MAX_STREAK; in that case grant fetch.
  - On a grant: latch addr, we and wdata into the mem_* registers, set mem_req_o=1, and go to the matching busy state.
  - A fetch grant forces mem_we_o=0.
- **ARB_BUSY_x**
  - mem_* registers are held constant.
  - If mem_ready_i: x_valid_o=1 and x_rdata_o=mem_rdata_i combinationally, same cycle. Next state ARB_IDLE; mem_req_o cleared.
  - Timeout: the timer counts cycles in the busy state. When it reaches TIMEOUT-1 with no mem_ready_i: x_valid_o=1, x_rdata_o=0, err_o=1, next state ARB_IDLE.
  - mem_ready_i on that same cycle wins; no error is reported.
- **Streak counter** (width $clog2(MAX_STREAK+1)):
  - Increments on a data grant while if_req_i=1, saturating at MAX_STREAK.
  - Clears on a fetch grant, or on any IDLE arbitration with if_req_i=0.
- **Stalls** (combinational):
  - stall_if_o = if_req_i & ~if_valid_o.
  - stall_mem_o = dm_req_i & ~dm_valid_o.
- rdata outputs are 0 when the matching valid is low.
- mem_ready_i seen in ARB_IDLE is ignored.

## Timing
- Reset:
  - State ARB_IDLE; streak and timer 0.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o all 0.
  - All valid outputs and err_o are 0.
- Reset asserted mid-access drops mem_req_o immediately and abandons the access; the memory must tolerate this.
- Latency:
  - Request seen in IDLE at cycle N gives mem_req_o=1 at N+1.
  - Earliest valid is N+1, when mem_ready_i=1 at N+1.
  - Minimum 2 cycles per access. Back-to-back accesses are separated by one IDLE cycle.
- Requester rules:
  - The requester drops req or changes addr in the cycle after valid.
  - A req that is still high in the IDLE cycle after valid counts as a new request.
- Data and fetch requests arriving in the same IDLE cycle: data is served first, then fetch on the following IDLE (streak=1, guard not yet needed).

## Structure
- Shared package riscv_mem_pkg holds:
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_DM}
  - typedef enum logic {GNT_IF, GNT_DM} arb_gnt_e
  - default widths ADDR_W and DATA_W
- One natural sub-module, arb_timeout_timer: load on grant, count while busy, report expiry.
- Streak logic and the FSM live in mem_port_arbiter.

## Test plan
- **Single load**: dm_req_i=1, dm_we_i=0, dm_addr_i=0x100; memory returns 0xDEADBEEF with mem_ready_i at the second busy cycle.
  - mem_req_o high 2 cycles with mem_addr_o=0x100, mem_we_o=0.
  - dm_valid_o one cycle with dm_rdata_o=0xDEADBEEF.
  - stall_mem_o high until the valid cycle.
- **Simultaneous fetch and store**: if_addr_i=0x40, dm_addr_i=0x200, dm_wdata_i=0x12345678, zero-wait memory.
  - Store to 0x200 (mem_we_o=1) is issued first.
  - Fetch at 0x40 follows after one IDLE cycle; stall_if_o stays high throughout.
- **Starvation guard**: MAX_STREAK=4; fetch held high with data requests continuous.
  - Exactly 4 data grants occur, then a fetch grant, then data resumes.
- **Timeout**: TIMEOUT=16, mem_ready_i tied 0 during a fetch to 0x80.
  - if_valid_o=1, if_rdata_o=0, err_o=1 on the 16th busy cycle.
  - mem_req_o=0 on the following cycle.
- **Reset mid-access**: rst_n pulsed low during ARB_BUSY_DM.
  - mem_req_o, dm_valid_o and err_o drop to 0 asynchronously.
  - After release with dm_req_i held, a fresh grant is issued from ARB_IDLE.
- **Late ready vs timeout**: mem_ready_i=1 exactly on the timeout cycle.
  - Valid with mem_rdata_i data; err_o stays 0.
